// File: rtl/dual_priority_decoder_12b.sv
// Rebuilds the 12-bit request vector of a dual priority encoder from a "first"/"second"
// code pair keyed in on a 4-bit input and confirmed by a debounced push button.
module dual_priority_decoder_12b #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  idx_in,
    input  logic        load_btn,
    output logic [11:0] req,
    output logic [3:0]  first,
    output logic [3:0]  second,
    output logic        valid,
    output logic [1:0]  state,
    output logic        err
);

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_SHOW   = 2'd2,
        S_BAD    = 2'd3
    } state_t;

    logic             r_sync1, r_sync2;
    logic             r_db, r_db_d;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load_evt;

    state_t           r_state, w_state_next;
    logic [3:0]       r_first, w_first_next;
    logic [3:0]       r_second, w_second_next;
    logic             r_err, w_err_next;
    logic [11:0]      r_req, w_req_next;
    logic             r_valid;
    logic [11:0]      w_first_bit, w_second_bit;

    // The debounced level only follows the synchronised button after DB_CYCLES agreeing samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= load_btn;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_load_evt = r_db & ~r_db_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_FIRST;
            r_first  <= 4'd0;
            r_second <= 4'd0;
            r_err    <= 1'b0;
            r_req    <= 12'd0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_first  <= w_first_next;
            r_second <= w_second_next;
            r_err    <= w_err_next;
            r_req    <= w_req_next;
            r_valid  <= (r_state == S_SHOW);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_first_next  = r_first;
        w_second_next = r_second;
        w_err_next    = 1'b0;
        case (r_state)
            S_FIRST: begin
                if (w_load_evt) begin
                    if (idx_in > 4'd12) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_first_next  = idx_in;
                        w_second_next = 4'd0;
                        w_state_next  = (idx_in == 4'd0) ? S_SHOW : S_SECOND;
                    end
                end
            end
            S_SECOND: begin
                // second must stay strictly below first so the encoder maps req back to this pair
                if (w_load_evt) begin
                    if ((idx_in > 4'd12) || ((idx_in != 4'd0) && (idx_in >= r_first))) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_second_next = idx_in;
                        w_state_next  = S_SHOW;
                    end
                end
            end
            S_SHOW: begin
                if (w_load_evt) begin
                    w_first_next  = 4'd0;
                    w_second_next = 4'd0;
                    w_state_next  = S_FIRST;
                end
            end
            default: begin
                w_first_next  = 4'd0;
                w_second_next = 4'd0;
                w_state_next  = S_FIRST;
            end
        endcase
    end

    always_comb begin
        w_first_bit  = (r_first  != 4'd0) ? (12'd1 << (r_first  - 4'd1)) : 12'd0;
        w_second_bit = (r_second != 4'd0) ? (12'd1 << (r_second - 4'd1)) : 12'd0;
        w_req_next   = (r_state == S_SHOW) ? (w_first_bit | w_second_bit) : 12'd0;
    end

    assign req    = r_req;
    assign first  = r_first;
    assign second = r_second;
    assign valid  = r_valid;
    assign state  = r_state;
    assign err    = r_err;

endmodule
